// File: rtl/spi_adc_responder_pkg.sv
// Shared constants for the MCP3002-style SPI ADC responder: sample width,
// command bit positions within {SGL, ODD, MSBF}, and the responder FSM states.
package spi_adc_responder_pkg;

    localparam int ADC_DATA_W = 10;

    localparam int CMD_SGL  = 2;
    localparam int CMD_ODD  = 1;
    localparam int CMD_MSBF = 0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_CMD        = 3'd2,
        ST_NULL       = 3'd3,
        ST_DATA_MSB   = 3'd4,
        ST_DATA_LSB   = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

endpackage

// File: rtl/spi_adc_responder_if.sv
// SPI pin bundle between the microphone initiator (master) and the ADC responder (slave).
interface spi_adc_responder_if;

    logic spi_clk;
    logic spi_mosi;
    logic spi_cs;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_clk,
        output spi_mosi,
        output spi_cs,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_clk,
        input  spi_mosi,
        input  spi_cs,
        output spi_miso,
        output spi_miso_oe
    );

endinterface

// File: rtl/spi_adc_responder_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus 1-clk rise/fall
// pulses taken from the last stage against one extra delay flop.
module spi_pin_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {STAGES{RESET_VAL}};
            dly_q   <= RESET_VAL;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], pin_i};
            dly_q   <= chain_q[STAGES-1];
        end
    end

    assign level_o = chain_q[STAGES-1];
    assign rise_o  = chain_q[STAGES-1] & ~dly_q;
    assign fall_o  = ~chain_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder emulating a 2-channel MCP3002-style ADC: oversamples the SPI pins
// on clk, decodes {start, SGL, ODD, MSBF} and shifts the latched sample out on MISO.
module spi_adc_responder
    import spi_adc_responder_pkg::*;
#(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    spi_adc_responder_if.slave bus,
    input  logic [DATA_W-1:0]  sample_ch0,
    input  logic [DATA_W-1:0]  sample_ch1,
    output logic               busy,
    output logic               conv_done,
    output logic [2:0]         last_cmd
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam int CNT_W = BIT_W + 1;
    localparam int SET_W = $clog2(SYNC_STAGES + 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .pin_i(bus.spi_clk),
        .level_o(sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .pin_i(bus.spi_cs),
        .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .pin_i(bus.spi_mosi),
        .level_o(mosi_level), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    assign unused_edges = ^{sclk_level, mosi_rise, mosi_fall};

    state_t             state_q;
    logic               miso_q, oe_q, busy_q, conv_done_q;
    logic [2:0]         last_cmd_q;
    logic [1:0]         cmd_q;
    logic [2:0]         cmd_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  latched_q, sample_d;
    logic [DATA_W-1:0]  op_a, op_b;
    logic [DATA_W:0]    diff;
    logic [SET_W-1:0]   settle_q;
    logic               armed_q;

    // Differential modes subtract in DATA_W+1 bits so the borrow acts as the sign.
    always_comb begin
        cmd_d = {cmd_q, mosi_level};
        op_a  = cmd_d[CMD_ODD] ? sample_ch1 : sample_ch0;
        op_b  = cmd_d[CMD_ODD] ? sample_ch0 : sample_ch1;
        diff  = {1'b0, op_a} - {1'b0, op_b};
        if (cmd_d[CMD_SGL]) begin
            sample_d = op_a;
        end else if (diff[DATA_W]) begin
            sample_d = '0;
        end else begin
            sample_d = diff[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            conv_done_q <= 1'b0;
            last_cmd_q  <= 3'b000;
            cmd_q       <= 2'b00;
            cnt_q       <= '0;
            latched_q   <= '0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            conv_done_q <= 1'b0;
            // A CS already low when reset releases must not open a frame.
            if (settle_q != SET_W'(SYNC_STAGES)) begin
                settle_q <= settle_q + 1'b1;
            end else if (cs_level) begin
                armed_q <= 1'b1;
            end

            if (cs_rise && state_q != ST_IDLE) begin
                state_q <= ST_IDLE;
                oe_q    <= 1'b0;
                miso_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (cs_fall && armed_q) begin
                            state_q <= ST_WAIT_START;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_WAIT_START: begin
                        if (sclk_rise && mosi_level) begin
                            state_q <= ST_CMD;
                            cnt_q   <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            cmd_q <= cmd_d[1:0];
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == CNT_W'(2)) begin
                                last_cmd_q <= cmd_d;
                                latched_q  <= sample_d;
                                state_q    <= ST_NULL;
                            end
                        end
                    end
                    ST_NULL: begin
                        if (sclk_fall) begin
                            oe_q    <= 1'b1;
                            miso_q  <= 1'b0;
                            cnt_q   <= CNT_W'(DATA_W - 1);
                            state_q <= ST_DATA_MSB;
                        end
                    end
                    ST_DATA_MSB: begin
                        if (sclk_fall) begin
                            // Index wraps past zero into the top bit once bit 0 has gone out.
                            if (cnt_q[CNT_W-1]) begin
                                if (last_cmd_q[CMD_MSBF]) begin
                                    state_q     <= ST_DONE;
                                    miso_q      <= 1'b0;
                                    conv_done_q <= 1'b1;
                                end else begin
                                    state_q <= ST_DATA_LSB;
                                    miso_q  <= latched_q[1];
                                    cnt_q   <= CNT_W'(2);
                                end
                            end else begin
                                miso_q <= latched_q[cnt_q[BIT_W-1:0]];
                                cnt_q  <= cnt_q - 1'b1;
                            end
                        end
                    end
                    ST_DATA_LSB: begin
                        if (sclk_fall) begin
                            if (cnt_q == CNT_W'(DATA_W)) begin
                                state_q     <= ST_DONE;
                                miso_q      <= 1'b0;
                                conv_done_q <= 1'b1;
                            end else begin
                                miso_q <= latched_q[cnt_q[BIT_W-1:0]];
                                cnt_q  <= cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        miso_q <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = oe_q;
    assign busy            = busy_q;
    assign conv_done       = conv_done_q;
    assign last_cmd        = last_cmd_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Randomized bench for spi_adc_responder: the initiator tasks push expected frames,
// a monitor captures MISO on SCLK rises and scores each frame at conv_done.
`timescale 1ns/1ps
module tb_spi_adc_responder;

    localparam int DATA_W = 10;
    localparam int SYNC   = 2;
    localparam int HALF   = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] sample_ch0, sample_ch1;
    logic              busy, conv_done;
    logic [2:0]        last_cmd;

    spi_adc_responder_if bus();

    spi_adc_responder #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .sample_ch0(sample_ch0),
        .sample_ch1(sample_ch1),
        .busy(busy),
        .conv_done(conv_done),
        .last_cmd(last_cmd)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_val_q[$];
    logic [2:0] exp_cmd_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Conversion result as the ADC datasheet defines it.
    function automatic int ref_value(input int c0, input int c1, input bit sgl, input bit odd);
        int d;
        if (sgl) return odd ? c1 : c0;
        d = odd ? (c1 - c0) : (c0 - c1);
        return (d < 0) ? 0 : d;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] cap_word = '0;
    int          cap_n = 0;
    logic        sclk_prev = 1'b0, cs_prev = 1'b1, done_prev = 1'b0, done_in_frame = 1'b0;
    logic [31:0] e_word;
    int          e_n, m_val, frame_no = 0;
    logic [2:0]  m_cmd;

    always @(negedge clk) begin
        if (bus.spi_clk && !sclk_prev && bus.spi_miso_oe) begin
            cap_word = {cap_word[30:0], bus.spi_miso};
            cap_n++;
        end
        if (conv_done) begin
            n_checks++;
            if (done_prev) begin
                n_fail++;
                $display("FAIL conv_done_width: got pulse longer than 1 clk, expected 1 clk");
            end else if (exp_val_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_conv_done: got a pulse, expected none");
            end else begin
                m_val  = exp_val_q.pop_front();
                m_cmd  = exp_cmd_q.pop_front();
                e_word = '0;
                e_n    = 1;
                for (int i = DATA_W - 1; i >= 0; i--) begin
                    e_word = {e_word[30:0], m_val[i]};
                    e_n++;
                end
                if (!m_cmd[0]) begin
                    for (int i = 1; i < DATA_W; i++) begin
                        e_word = {e_word[30:0], m_val[i]};
                        e_n++;
                    end
                end
                if (cap_n != e_n || cap_word != e_word) begin
                    n_fail++;
                    $display("FAIL miso_word: got %0d bits 0x%0h, expected %0d bits 0x%0h",
                             cap_n, cap_word, e_n, e_word);
                end
                check("last_cmd", int'(last_cmd), int'(m_cmd));
                frame_no++;
                $display("frame %0d: cmd=%b value=0x%03h miso_bits=%0d", frame_no, m_cmd, m_val, cap_n);
            end
            cap_word      = '0;
            cap_n         = 0;
            done_in_frame = 1'b1;
        end
        if (bus.spi_cs && !cs_prev) begin
            if (done_in_frame && cap_n > 0) check("miso_after_done", int'(cap_word), 0);
            cap_word      = '0;
            cap_n         = 0;
            done_in_frame = 1'b0;
        end
        sclk_prev = bus.spi_clk;
        cs_prev   = bus.spi_cs;
        done_prev = conv_done;
    end

    // ---------------- initiator ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sclk_cycle(input logic mosi_b);
        bus.spi_mosi = mosi_b;
        wait_clk(HALF);
        bus.spi_clk = 1'b1;
        wait_clk(HALF);
        bus.spi_clk = 1'b0;
    endtask

    task automatic run_frame(input int lead0, input logic [2:0] cmd, input int abort_after, input int extra);
        int v, ndata;
        bus.spi_cs = 1'b0;
        wait_clk(HALF);
        check("busy_in_frame", int'(busy), 1);
        for (int i = 0; i < lead0; i++) sclk_cycle(1'b0);
        sclk_cycle(1'b1);
        sclk_cycle(cmd[2]);
        sclk_cycle(cmd[1]);
        v = ref_value(int'(sample_ch0), int'(sample_ch1), cmd[2], cmd[1]);
        sclk_cycle(cmd[0]);
        // Only the value present at the latch instant may be returned.
        sample_ch0 = DATA_W'($urandom);
        sample_ch1 = DATA_W'($urandom);
        if (abort_after >= 0) begin
            for (int i = 0; i < abort_after; i++) sclk_cycle(1'b0);
            bus.spi_cs = 1'b1;
            for (int k = 0; k < SYNC + 2 && bus.spi_miso_oe; k++) wait_clk(1);
            check("abort_oe", int'(bus.spi_miso_oe), 0);
            wait_clk(HALF);
            check("abort_busy", int'(busy), 0);
            check("abort_last_cmd", int'(last_cmd), int'(cmd));
            $display("abort: cmd=%b after %0d data clocks", cmd, abort_after);
        end else begin
            exp_val_q.push_back(v);
            exp_cmd_q.push_back(cmd);
            ndata = 1 + DATA_W + (cmd[0] ? 0 : DATA_W - 1);
            for (int i = 0; i < ndata + extra; i++) sclk_cycle(1'b0);
            wait_clk(HALF);
            bus.spi_cs = 1'b1;
            wait_clk(2 * HALF);
            check("idle_busy", int'(busy), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected finish before 2 ms");
        $fatal(1);
    end

    initial begin
        logic any_active;
        rst          = 1'b1;
        bus.spi_cs   = 1'b1;
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = 1'b0;
        sample_ch0   = '0;
        sample_ch1   = '0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(1);
        check("rst_miso", int'(bus.spi_miso), 0);
        check("rst_oe", int'(bus.spi_miso_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_conv_done", int'(conv_done), 0);
        check("rst_last_cmd", int'(last_cmd), 0);
        wait_clk(10);

        sample_ch0 = 10'h2A5; sample_ch1 = 10'h100;
        run_frame(0, 3'b101, -1, 0);
        sample_ch1 = 10'h3FF;
        run_frame(0, 3'b110, -1, 2);
        sample_ch0 = 10'h300; sample_ch1 = 10'h100;
        run_frame(0, 3'b001, -1, 0);
        sample_ch0 = 10'h300; sample_ch1 = 10'h100;
        run_frame(0, 3'b011, -1, 0);
        sample_ch0 = 10'h155;
        run_frame(3, 3'b101, -1, 1);
        sample_ch0 = 10'h0F0; sample_ch1 = 10'h20F;
        run_frame(0, 3'b111, 5, 0);
        sample_ch0 = 10'h0F0; sample_ch1 = 10'h20F;
        run_frame(0, 3'b110, -1, 0);

        // Reset in the middle of the data phase with CS held low.
        sample_ch0 = 10'h1C3;
        bus.spi_cs = 1'b0;
        wait_clk(HALF);
        sclk_cycle(1'b1); sclk_cycle(1'b1); sclk_cycle(1'b0); sclk_cycle(1'b1);
        for (int i = 0; i < 6; i++) sclk_cycle(1'b0);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        check("midrst_miso", int'(bus.spi_miso), 0);
        check("midrst_oe", int'(bus.spi_miso_oe), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_conv_done", int'(conv_done), 0);
        check("midrst_last_cmd", int'(last_cmd), 0);
        any_active = 1'b0;
        sclk_cycle(1'b1); sclk_cycle(1'b1); sclk_cycle(1'b0); sclk_cycle(1'b1);
        for (int i = 0; i < 12; i++) begin
            sclk_cycle(1'b0);
            any_active = any_active | bus.spi_miso_oe | busy;
        end
        check("no_frame_after_rst", int'(any_active), 0);
        bus.spi_cs = 1'b1;
        wait_clk(2 * HALF);
        sample_ch0 = 10'h1C3;
        run_frame(0, 3'b101, -1, 0);

        for (int f = 0; f < 40; f++) begin
            logic [2:0] cmd;
            cmd        = 3'($urandom);
            sample_ch0 = DATA_W'($urandom);
            sample_ch1 = DATA_W'($urandom);
            if ($urandom_range(0, 7) == 0)
                run_frame($urandom_range(0, 3), cmd, $urandom_range(1, 10), 0);
            else
                run_frame($urandom_range(0, 3), cmd, -1, $urandom_range(0, 2));
        end

        wait_clk(50);
        check("pending_frames", exp_val_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
